// File: rtl/register_read_buffer.sv
// Circular buffer that captures strobed writes (no backpressure) and presents them
// to a consumer over a val/rdy handshake; writes arriving while full are dropped and flagged.
module register_read_buffer #(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     w,
  input  logic [n-1:0]             d,
  output logic                     q_val,
  input  logic                     q_rdy,
  output logic [n-1:0]             q_msg,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [n-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic          q_val_s;
  logic          full_s;
  logic          pop_s;
  logic          accept_s;
  logic          drop_s;

  // Handshake decode and output formation from registered state only
  always_comb begin
    q_val_s  = 1'b0;
    full_s   = 1'b0;
    pop_s    = 1'b0;
    accept_s = 1'b0;
    drop_s   = 1'b0;
    q_msg    = {n{1'b0}};
    if (count_r != {CW{1'b0}}) begin
      q_val_s = 1'b1;
      q_msg   = mem_r[rd_ptr_r];
    end else begin
      q_val_s = 1'b0;
    end
    full_s   = (count_r == CNT_FULL);
    pop_s    = q_val_s && q_rdy;
    // A pop in the same cycle frees the slot the incoming write needs
    accept_s = w && (!full_s || pop_s);
    drop_s   = w && full_s && !pop_s;
  end

  assign q_val    = q_val_s;
  assign full     = full_s;
  assign count    = count_r;
  assign overflow = overflow_r;

  // Storage array: no reset, only written on accepted writes outside reset
  always_ff @(posedge clk) begin
    if (accept_s && !reset) begin
      mem_r[wr_ptr_r] <= d;
    end
  end

  // Pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // A drop outranks a concurrent clear so no lost write goes unreported
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule
